// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - 9-way request arbiter with one-hot/encoded grant and hold-time limit
// Fixed priority (line 8 highest) by default; define ARB_ROUND_ROBIN_EN for rotating priority.
module req_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] req,
    output logic [8:0] gnt,
    output logic [3:0] gnt_code,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] owner_q, owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [8:0] gnt_q, gnt_d;
    logic [3:0] gnt_code_q, gnt_code_d;
    logic       timeout_q, timeout_d;
    logic       revoke;
    logic [3:0] search_start;
    logic [3:0] winner;

`ifdef ARB_ROUND_ROBIN_EN
    logic [3:0] last_idx_q, last_idx_d;
`endif

    // First set line found scanning downward from start, wrapping 0 -> 8.
    function automatic logic [3:0] pick(input logic [8:0] r, input logic [3:0] start);
        logic [3:0] w;
        int         idx;
        w = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            idx = (int'(start) - k + 9) % 9;
            if (r[idx]) w = 4'(idx);
        end
        return w;
    endfunction

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        search_start = (last_idx_q == 4'd0) ? 4'd8 : last_idx_q - 4'd1;
`else
        search_start = 4'd8;
`endif
        winner = pick(req, search_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 4'd0;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 9'd0;
            gnt_code_q <= 4'd0;
            timeout_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_idx_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_code_q <= gnt_code_d;
            timeout_q  <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_idx_q <= last_idx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        revoke     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_idx_d = last_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    owner_d    = winner;
                    hold_cnt_d = 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_idx_d = winner;
`endif
                end
            end
            GRANT: begin
                // An owner drop wins over a coincident timeout: plain release.
                if (!req[owner_q]) begin
                    state_d    = IDLE;
                    hold_cnt_d = 8'd0;
                end else if (MAX_HOLD == 0 || hold_cnt_q < MAX_HOLD_C) begin
                    if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    state_d    = IDLE;
                    hold_cnt_d = 8'd0;
                    revoke     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = 9'd0;
        gnt_code_d = 4'd0;
        timeout_d  = revoke;
        if (state_d == GRANT) begin
            gnt_d      = 9'd1 << owner_d;
            gnt_code_d = owner_d + 4'd1;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_code  = gnt_code_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - directed scoreboard bench for req_arbiter
module tb_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] req, req1;
    logic [8:0] gnt, gnt1;
    logic [3:0] gnt_code, gnt_code1;
    logic       gnt_valid, gnt_valid1;
    logic       timeout, timeout1;

    int vectors = 0;
    int errs    = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    req_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_code(gnt_code),
        .gnt_valid(gnt_valid), .timeout(timeout)
    );

    req_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .gnt_code(gnt_code1),
        .gnt_valid(gnt_valid1), .timeout(timeout1)
    );

    task automatic check(input string tag, input logic [8:0] og, input logic [3:0] oc,
                         input logic ov, input logic ot);
        logic [4:0] e;
        logic [3:0] ec;
        logic [8:0] eg;
        e  = exp_q.pop_front();
        ec = e[3:0];
        eg = (ec == 4'd0) ? 9'd0 : (9'd1 << (ec - 4'd1));
        vectors++;
        assert (oc === ec) else begin
            errs++;
            $error("FAIL %s gnt_code got %0d want %0d", tag, oc, ec);
        end
        vectors++;
        assert (og === eg) else begin
            errs++;
            $error("FAIL %s gnt got %h want %h", tag, og, eg);
        end
        vectors++;
        assert (ov === (ec != 4'd0)) else begin
            errs++;
            $error("FAIL %s gnt_valid got %b want %b", tag, ov, (ec != 4'd0));
        end
        vectors++;
        assert (ot === e[4]) else begin
            errs++;
            $error("FAIL %s timeout got %b want %b", tag, ot, e[4]);
        end
    endtask

    task automatic cyc(input string tag, input logic [8:0] r, input logic [3:0] code, input logic to);
        req = r;
        exp_q.push_back({to, code});
        @(posedge clk);
        #1;
        check(tag, gnt, gnt_code, gnt_valid, timeout);
    endtask

    task automatic cyc1(input string tag, input logic [8:0] r, input logic [3:0] code, input logic to);
        req1 = r;
        exp_q.push_back({to, code});
        @(posedge clk);
        #1;
        check(tag, gnt1, gnt_code1, gnt_valid1, timeout1);
    endtask

    task automatic now(input string tag, input logic [3:0] code, input logic to);
        exp_q.push_back({to, code});
        check(tag, gnt, gnt_code, gnt_valid, timeout);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 9'h1FF;
        req1 = 9'h000;
        repeat (2) @(posedge clk);
        #1;
        now("reset", 4'd0, 1'b0);
        rst = 1'b0;
        cyc("post_reset", 9'h1FF, 4'd9, 1'b0);
        cyc("post_reset_rel", 9'h000, 4'd0, 1'b0);

        for (int i = 0; i < 3; i++) cyc("single", 9'h001, 4'd1, 1'b0);
        cyc("single_rel", 9'h000, 4'd0, 1'b0);
        cyc("idle", 9'h000, 4'd0, 1'b0);

        for (int i = 0; i < 8; i++) cyc("hold5", 9'h020, 4'd6, 1'b0);
        cyc("timeout5", 9'h020, 4'd0, 1'b1);
        cyc("regrant5", 9'h020, 4'd6, 1'b0);
        cyc("rel5", 9'h000, 4'd0, 1'b0);

        cyc("own2", 9'h004, 4'd3, 1'b0);
        cyc("nopreempt", 9'h084, 4'd3, 1'b0);
        cyc("nopreempt", 9'h084, 4'd3, 1'b0);
        cyc("gap", 9'h080, 4'd0, 1'b0);
        cyc("next7", 9'h080, 4'd8, 1'b0);
        cyc("rel7", 9'h000, 4'd0, 1'b0);

        cyc("simul", 9'h0A5, 4'd8, 1'b0);
        cyc("simul_rel", 9'h000, 4'd0, 1'b0);

        for (int i = 0; i < 8; i++) cyc("hold1", 9'h002, 4'd2, 1'b0);
        cyc("drop_at_limit", 9'h000, 4'd0, 1'b0);

        cyc("own3", 9'h008, 4'd4, 1'b0);
        cyc("own3", 9'h008, 4'd4, 1'b0);
        #3 rst = 1'b1;
        #1;
        now("async_reset", 4'd0, 1'b0);
        #1 rst = 1'b0;
        cyc("after_areset", 9'h008, 4'd4, 1'b0);
        cyc("after_areset_rel", 9'h000, 4'd0, 1'b0);

        for (int i = 9; i >= 1; i--) begin
`ifdef ARB_ROUND_ROBIN_EN
            cyc1("rotate", 9'h1FF, 4'(i), 1'b0);
`else
            cyc1("rotate", 9'h1FF, 4'd9, 1'b0);
`endif
            cyc1("rotate_to", 9'h1FF, 4'd0, 1'b1);
        end
        cyc1("rotate_wrap", 9'h1FF, 4'd9, 1'b0);
        cyc1("rotate_rel", 9'h000, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
